// File: rtl/imem_loader.sv
// imem_loader: loads a program image into instruction memory from a byte
// stream while the core is held in reset. Big-endian bytes are packed into
// 32-bit words and written to consecutive word addresses from 0.
module imem_loader #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    input  logic          in_last,
    output logic          in_ready,
    output logic          mem_we,
    output logic [AW-1:0] mem_wa,
    output logic [31:0]   mem_wd,
    output logic          busy,
    output logic          done,
    output logic          cpu_reset,
    output logic [AW:0]   words_written
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [1:0]  byte_idx;
    logic [31:0] asm_word;
    logic [31:0] word_next;
    logic        done_seen;
    logic        accept;
    logic        commit;
    logic        final_word;

    // in_ready depends on state only, so accept never loops back through it
    assign in_ready   = (state == LOAD);
    assign busy       = (state == LOAD);
    assign done       = (state == DONE);
    assign accept     = in_valid && (state == LOAD);
    assign commit     = accept && ((byte_idx == 2'd3) || in_last);
    assign final_word = (words_written == (AW+1)'(DEPTH - 1));

    // core stays in reset through the first DONE cycle so the last write lands first
    assign cpu_reset  = !((state == DONE) && done_seen);

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // next-state decode
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (start) state_next = LOAD;
            LOAD: if (commit && (in_last || final_word)) state_next = DONE;
            DONE: if (start) state_next = LOAD;
            default: state_next = IDLE;
        endcase
    end

    // place the incoming byte into its big-endian lane
    always_comb begin
        word_next = asm_word;
        unique case (byte_idx)
            2'd0: word_next[31:24] = in_data;
            2'd1: word_next[23:16] = in_data;
            2'd2: word_next[15:8]  = in_data;
            2'd3: word_next[7:0]   = in_data;
        endcase
    end

    // word assembly, write port and load counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_idx      <= 2'd0;
            asm_word      <= '0;
            words_written <= '0;
            mem_we        <= 1'b0;
            mem_wa        <= '0;
            mem_wd        <= '0;
            done_seen     <= 1'b0;
        end else begin
            mem_we    <= 1'b0;
            done_seen <= (state == DONE);
            if ((state != LOAD) && start) begin
                byte_idx      <= 2'd0;
                asm_word      <= '0;
                words_written <= '0;
            end else if (accept) begin
                if (commit) begin
                    mem_we        <= 1'b1;
                    mem_wa        <= words_written[AW-1:0];
                    mem_wd        <= word_next;
                    words_written <= words_written + (AW+1)'(1);
                    byte_idx      <= 2'd0;
                    asm_word      <= '0;
                end else begin
                    asm_word <= word_next;
                    byte_idx <= byte_idx + 2'd1;
                end
            end
        end
    end

endmodule
